// File: rtl/rocketcpu_param_smoother.sv
// rocketcpu_param_smoother: time-multiplexed one-pole smoother for CPU audio parameters
// Define PARAM_SMOOTH_SNAP_EN to add i_snap, which loads targets directly during a sweep.
module rocketcpu_param_smoother #(
  parameter int CHANNELS = 4,
  parameter int WIDTH = 16,
  parameter int SHIFT = 4
) (
  input  logic                      i_wb_clk,
  input  logic                      i_rst_n,
  input  logic                      i_sample_tick,
  input  logic [CHANNELS*WIDTH-1:0] i_target,
  input  logic                      i_overrun_clr,
`ifdef PARAM_SMOOTH_SNAP_EN
  input  logic                      i_snap,
`endif
  output logic [CHANNELS*WIDTH-1:0] o_value,
  output logic [CHANNELS-1:0]       o_settled,
  output logic                      o_busy,
  output logic                      o_sweep_done,
  output logic                      o_overrun
);
  localparam int IW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state;
  logic [IW-1:0] idx;
  logic signed [WIDTH-1:0] val [CHANNELS];
  logic signed [WIDTH-1:0] cur, tgt, nxt;
  logic signed [WIDTH:0] diff, step_raw, step;
  logic snap;
`ifdef PARAM_SMOOTH_SNAP_EN
  assign snap = i_snap;
`else
  assign snap = 1'b0;
`endif
  // diff is one bit wider so full-scale swings cannot wrap; the +1 floor makes positive approach exact
  always_comb begin
    cur = val[idx];
    tgt = i_target[idx*WIDTH +: WIDTH];
    diff = {tgt[WIDTH-1], tgt} - {cur[WIDTH-1], cur};
    step_raw = diff >>> SHIFT;
    step = (step_raw == '0 && diff > 0) ? (WIDTH+1)'(1) : step_raw;
    nxt = snap ? tgt : WIDTH'(cur + step);
  end
  always_ff @(posedge i_wb_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
      idx <= '0;
      o_busy <= 1'b0;
      o_sweep_done <= 1'b0;
      o_overrun <= 1'b0;
      o_settled <= '0;
      for (int i = 0; i < CHANNELS; i++) val[i] <= '0;
    end else begin
      o_sweep_done <= 1'b0;
      if (i_sample_tick && state == SWEEP) o_overrun <= 1'b1;
      else if (i_overrun_clr) o_overrun <= 1'b0;
      if (state == IDLE) begin
        if (i_sample_tick) begin
          state <= SWEEP;
          idx <= '0;
          o_busy <= 1'b1;
        end
      end else begin
        val[idx] <= nxt;
        o_settled[idx] <= nxt == tgt;
        if (idx == IW'(CHANNELS-1)) begin
          state <= IDLE;
          idx <= '0;
          o_busy <= 1'b0;
          o_sweep_done <= 1'b1;
        end else begin
          idx <= idx + IW'(1);
        end
      end
    end
  end
  for (genvar k = 0; k < CHANNELS; k++) begin : g_out
    assign o_value[k*WIDTH +: WIDTH] = val[k];
  end
endmodule

// File: tb/tb_rocketcpu_param_smoother.sv
// tb_rocketcpu_param_smoother: randomized checks of the smoother against an integer reference model
module tb_rocketcpu_param_smoother;
  localparam int C = 4;
  localparam int W = 16;
  localparam int SH = 2;
  logic i_wb_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_sample_tick = 1'b0;
  logic i_overrun_clr = 1'b0;
  logic [C*W-1:0] i_target = '0;
`ifdef PARAM_SMOOTH_SNAP_EN
  logic i_snap = 1'b0;
`endif
  logic [C*W-1:0] o_value;
  logic [C-1:0] o_settled;
  logic o_busy, o_sweep_done, o_overrun;
  int checks = 0;
  int errors = 0;
  int m_val [C];
  bit m_set [C];
  bit m_snap = 1'b0;

  always #5 i_wb_clk = ~i_wb_clk;

  rocketcpu_param_smoother #(.CHANNELS(C), .WIDTH(W), .SHIFT(SH)) dut (
    .i_wb_clk(i_wb_clk),
    .i_rst_n(i_rst_n),
    .i_sample_tick(i_sample_tick),
    .i_target(i_target),
    .i_overrun_clr(i_overrun_clr),
`ifdef PARAM_SMOOTH_SNAP_EN
    .i_snap(i_snap),
`endif
    .o_value(o_value),
    .o_settled(o_settled),
    .o_busy(o_busy),
    .o_sweep_done(o_sweep_done),
    .o_overrun(o_overrun)
  );

  task automatic step();
    @(posedge i_wb_clk);
    #1;
  endtask

  function automatic int dut_val(input int k);
    return int'($signed(o_value[k*W +: W]));
  endfunction

  function automatic int tgt_of(input int k);
    return int'($signed(i_target[k*W +: W]));
  endfunction

  task automatic set_tgt(input int k, input int v);
    i_target[k*W +: W] = W'(v);
  endtask

  // floor division toward -inf, then a minimum +1 nudge for small positive gaps
  function automatic int smooth(input int cur, input int tgt);
    int d, q, s;
    d = tgt - cur;
    q = 1 << SH;
    s = (d >= 0) ? d / q : -((-d + q - 1) / q);
    if (s == 0 && d > 0) s = 1;
    return cur + s;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < C; k++) begin
      m_val[k] = 0;
      m_set[k] = 1'b0;
    end
  endtask

  task automatic apply_reset();
    i_rst_n = 1'b0;
    i_sample_tick = 1'b0;
    i_overrun_clr = 1'b0;
    step();
    step();
    i_rst_n = 1'b1;
    model_reset();
  endtask

  // one tick-started sweep; returns in the cycle where o_sweep_done should be high
  task automatic sweep(input string tag, input bit extra, input bit extra_clr, input bit rnd);
    int tv;
    i_sample_tick = 1'b1;
    step();
    i_sample_tick = 1'b0;
    for (int k = 0; k < C; k++) begin
      checks++;
      if (o_busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy cyc%0d got %b exp 1", tag, k, o_busy);
      end
      if (rnd) i_target = {$urandom, $urandom};
      tv = tgt_of(k);
      m_val[k] = m_snap ? tv : smooth(m_val[k], tv);
      m_set[k] = (m_val[k] == tv);
      if (extra && k == 1) begin
        i_sample_tick = 1'b1;
        i_overrun_clr = extra_clr;
      end
      step();
      i_sample_tick = 1'b0;
      i_overrun_clr = 1'b0;
      for (int j = 0; j < C; j++) begin
        checks++;
        if (dut_val(j) !== m_val[j] || o_settled[j] !== m_set[j]) begin
          errors++;
          $display("FAIL %s value ch%0d after cyc%0d got %0d/%b exp %0d/%b", tag, j, k, dut_val(j), o_settled[j], m_val[j], m_set[j]);
        end
      end
      checks++;
      if (o_sweep_done !== (k == C-1)) begin
        errors++;
        $display("FAIL %s sweep_done cyc%0d got %b exp %b", tag, k, o_sweep_done, k == C-1);
      end
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_end got %b exp 0", tag, o_busy);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (o_value !== '0 || o_settled !== '0 || o_busy !== 1'b0 || o_sweep_done !== 1'b0 || o_overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset got val=%h set=%b busy=%b done=%b ovr=%b exp all 0", o_value, o_settled, o_busy, o_sweep_done, o_overrun);
    end
  endtask

  task automatic test_ramp();
    int exp_v [3] = '{250, 437, 577};
    apply_reset();
    i_target = '0;
    set_tgt(0, 1000);
    for (int i = 0; i < 3; i++) begin
      sweep("ramp", 1'b0, 1'b0, 1'b0);
      checks++;
      if (dut_val(0) !== exp_v[i]) begin
        errors++;
        $display("FAIL ramp ch0 sweep%0d got %0d exp %0d", i, dut_val(0), exp_v[i]);
      end
      step();
      checks++;
      if (o_sweep_done !== 1'b0 || o_busy !== 1'b0) begin
        errors++;
        $display("FAIL ramp idle got done=%b busy=%b exp 0/0", o_sweep_done, o_busy);
      end
    end
  endtask

  task automatic test_small_step();
    apply_reset();
    i_target = '0;
    set_tgt(1, 3);
    set_tgt(2, -3);
    for (int i = 0; i < 3; i++) begin
      sweep("small", 1'b0, 1'b0, 1'b0);
      step();
      checks++;
      if (dut_val(1) !== i + 1 || dut_val(2) !== -(i + 1) || o_settled[1] !== (i == 2) || o_settled[2] !== (i == 2)) begin
        errors++;
        $display("FAIL small sweep%0d got ch1=%0d ch2=%0d set=%b exp %0d %0d settled=%b", i, dut_val(1), dut_val(2), o_settled, i + 1, -(i + 1), i == 2);
      end
    end
  endtask

  task automatic test_extremes();
    apply_reset();
    i_target = '0;
    set_tgt(3, -32768);
    for (int i = 0; i < 100 && !m_set[3]; i++) sweep("ext_lo", 1'b0, 1'b0, 1'b0);
    checks++;
    if (dut_val(3) !== -32768) begin
      errors++;
      $display("FAIL ext_converge_lo got %0d exp -32768", dut_val(3));
    end
    set_tgt(3, 32767);
    sweep("ext_up", 1'b0, 1'b0, 1'b0);
    checks++;
    if (dut_val(3) !== -16385) begin
      errors++;
      $display("FAIL ext_up got %0d exp -16385", dut_val(3));
    end
    for (int i = 0; i < 100 && !m_set[3]; i++) sweep("ext_hi", 1'b0, 1'b0, 1'b0);
    set_tgt(3, -32768);
    sweep("ext_down", 1'b0, 1'b0, 1'b0);
    checks++;
    if (dut_val(3) !== 16383) begin
      errors++;
      $display("FAIL ext_down got %0d exp 16383", dut_val(3));
    end
    step();
  endtask

  task automatic test_overrun();
    i_overrun_clr = 1'b1;
    step();
    i_overrun_clr = 1'b0;
    for (int k = 0; k < C; k++) set_tgt(k, int'($urandom_range(0, 65535)) - 32768);
    sweep("ovr", 1'b1, 1'b0, 1'b0);
    checks++;
    if (o_overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set got %b exp 1", o_overrun);
    end
    step();
    checks++;
    if (o_busy !== 1'b0 || o_overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_idle got busy=%b ovr=%b exp 0/1", o_busy, o_overrun);
    end
    i_overrun_clr = 1'b1;
    step();
    i_overrun_clr = 1'b0;
    checks++;
    if (o_overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clr got %b exp 0", o_overrun);
    end
    sweep("ovr_both", 1'b1, 1'b1, 1'b0);
    checks++;
    if (o_overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set_and_clr got %b exp 1", o_overrun);
    end
    step();
    i_overrun_clr = 1'b1;
    step();
    i_overrun_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    sweep("b2b_a", 1'b0, 1'b0, 1'b1);
    sweep("b2b_b", 1'b0, 1'b0, 1'b1);
    sweep("b2b_c", 1'b0, 1'b0, 1'b1);
    checks++;
    if (o_overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_overrun got %b exp 0", o_overrun);
    end
    step();
  endtask

  task automatic test_midsweep_reset();
    apply_reset();
    for (int k = 0; k < C; k++) set_tgt(k, 1000 + k);
    i_sample_tick = 1'b1;
    step();
    i_sample_tick = 1'b0;
    step();
    i_rst_n = 1'b0;
    step();
    i_rst_n = 1'b1;
    model_reset();
    checks++;
    if (o_value !== '0 || o_settled !== '0 || o_busy !== 1'b0 || o_sweep_done !== 1'b0) begin
      errors++;
      $display("FAIL midrst got val=%h set=%b busy=%b done=%b exp all 0", o_value, o_settled, o_busy, o_sweep_done);
    end
    step();
    step();
    checks++;
    if (o_value !== '0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_hold got val=%h busy=%b exp 0/0", o_value, o_busy);
    end
    sweep("midrst_fresh", 1'b0, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      sweep("rand", 1'b0, 1'b0, 1'b1);
      if ($urandom_range(0, 1) == 1) step();
    end
    step();
  endtask

`ifdef PARAM_SMOOTH_SNAP_EN
  task automatic test_snap();
    for (int k = 0; k < C; k++) set_tgt(k, 16'h1234);
    i_snap = 1'b1;
    m_snap = 1'b1;
    sweep("snap", 1'b0, 1'b0, 1'b0);
    i_snap = 1'b0;
    m_snap = 1'b0;
    checks++;
    if (o_value !== {C{16'h1234}} || o_settled !== 4'b1111) begin
      errors++;
      $display("FAIL snap got val=%h set=%b exp all 1234/1111", o_value, o_settled);
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_ramp();
    test_small_step();
    test_extremes();
    test_overrun();
    test_back_to_back();
    test_midsweep_reset();
    test_random();
`ifdef PARAM_SMOOTH_SNAP_EN
    test_snap();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
